// File: rtl/serializer_arb_pkg.sv
// Shared types and defaults for the serializer round-robin scheduler.
//   arb_state_e : scheduler FSM states
//   DATA_W_DEF  : default serializer word width
//   MOD_W_DEF   : default length field width
//   MOD_FULL    : length encoding meaning "all DATA_W bits"
package serializer_arb_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned MOD_W_DEF  = 4;
    localparam int unsigned MOD_FULL   = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/serializer_arb_rr_pick.sv
// Combinational round-robin selector.
//   elig_i : eligible requester vector
//   ptr_i  : highest-priority index for this pick
//   gnt_o  : one-hot grant (zero when nothing is eligible)
//   idx_o  : binary index of the granted requester
//   any_o  : at least one requester is eligible
module serializer_arb_rr_pick
    import serializer_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // One spare bit so ptr + offset can exceed N_REQ-1 before wrapping.
    localparam int unsigned SUM_W = ID_W + 1;

    logic [SUM_W-1:0] pos;
    logic             found;

    // Walk the requesters starting at the pointer; first eligible one wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            pos = {1'b0, ptr_i} + SUM_W'(i);
            if (pos >= SUM_W'(N_REQ)) begin
                pos = pos - SUM_W'(N_REQ);
            end
            if (!found && elig_i[pos[ID_W-1:0]]) begin
                found                  = 1'b1;
                gnt_o[pos[ID_W-1:0]]   = 1'b1;
                idx_o                  = pos[ID_W-1:0];
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/serializer_arb.sv
// Round-robin scheduler sharing one serializer between N_REQ requesters.
// A word is accepted with a one-cycle ready strobe, launched with a
// one-cycle ser_val_o pulse, and the next grant waits until the
// serializer has raised and dropped ser_busy_i (or the launch timed out).
//   clk_i, srst_i       : clock, synchronous active-low reset
//   en_i                : per-requester enable mask
//   req_data_i/mod_i    : flattened requester words / lengths
//   req_val_i           : requester valid
//   req_ready_o         : one-hot accept strobe (combinational, IDLE only)
//   ser_data_o/mod_o    : word and length to the serializer (held)
//   ser_val_o           : one-cycle launch pulse
//   ser_busy_i          : serializer busy
//   grant_id_o/val_o    : owner of the serial line
//   drop_o              : launch produced no busy in time
//   busy_o              : scheduler not idle
module serializer_arb
    import serializer_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MOD_W   = MOD_W_DEF,
    parameter int unsigned BUSY_TO = 3,
    localparam int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic [N_REQ-1:0]        en_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ*MOD_W-1:0]  req_mod_i,
    input  logic [N_REQ-1:0]        req_val_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]       ser_data_o,
    output logic [MOD_W-1:0]        ser_mod_o,
    output logic                    ser_val_o,
    input  logic                    ser_busy_i,
    output logic [ID_W-1:0]         grant_id_o,
    output logic                    grant_val_o,
    output logic                    drop_o,
    output logic                    busy_o
);

    localparam int unsigned CNT_W = $clog2(BUSY_TO + 1);

    arb_state_e         state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  data_q;
    logic [MOD_W-1:0]   mod_q;
    logic               ser_val_q;
    logic               gval_q;
    logic               drop_q;
    logic               busy_q;

    logic [N_REQ-1:0]   elig_c;
    logic [N_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               launch_c;
    logic               timeout_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic [MOD_W-1:0]   sel_mod_c;

    assign elig_c = req_val_i & en_i;

    serializer_arb_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .elig_i (elig_c),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Grant only from IDLE, out of reset, with the serializer free.
    assign launch_c    = (state_q == IDLE) && srst_i && !ser_busy_i && pick_any;
    assign req_ready_o = launch_c ? pick_gnt : '0;

    // Pointer moves to the requester after the winner.
    assign ptr_d = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

    // Drop decision is taken so that drop_o lands exactly BUSY_TO cycles
    // after the ser_val_o pulse (BUSY_TO >= 2 assumed).
    assign timeout_c = (32'(cnt_q) + 32'd2) >= BUSY_TO;

    // Select the winner's word and length.
    always_comb begin
        sel_data_c = '0;
        sel_mod_c  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (pick_idx == ID_W'(k)) begin
                sel_data_c = req_data_i[k*DATA_W +: DATA_W];
                sel_mod_c  = req_mod_i[k*MOD_W +: MOD_W];
            end
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            mod_q     <= '0;
            ser_val_q <= 1'b0;
            gval_q    <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ser_val_q <= 1'b0;
            drop_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (launch_c) begin
                        data_q    <= sel_data_c;
                        mod_q     <= sel_mod_c;
                        id_q      <= pick_idx;
                        ptr_q     <= ptr_d;
                        ser_val_q <= 1'b1;
                        gval_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (ser_busy_i) begin
                        state_q <= WAIT_DONE;
                    end else if (timeout_c) begin
                        drop_q  <= 1'b1;
                        gval_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!ser_busy_i) begin
                        gval_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ser_data_o  = data_q;
    assign ser_mod_o   = mod_q;
    assign ser_val_o   = ser_val_q;
    assign grant_id_o  = id_q;
    assign grant_val_o = gval_q;
    assign drop_o      = drop_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_serializer_arb.sv
// Directed bench for serializer_arb with a small serializer stand-in:
// lengths 1 and 2 are rejected (never busy), others keep busy for
// len cycles (16 for the full-length code) starting the cycle after launch.
module tb_serializer_arb;
    import serializer_arb_pkg::*;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MOD_W   = 4;
    localparam int unsigned BUSY_TO = 3;

    logic                    clk_i = 1'b0;
    logic                    srst_i;
    logic [N_REQ-1:0]        en_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ*MOD_W-1:0]  req_mod_i;
    logic [N_REQ-1:0]        req_val_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [DATA_W-1:0]       ser_data_o;
    logic [MOD_W-1:0]        ser_mod_o;
    logic                    ser_val_o;
    logic                    ser_busy_i;
    logic [1:0]              grant_id_o;
    logic                    grant_val_o;
    logic                    drop_o;
    logic                    busy_o;

    int   checks = 0;
    int   errors = 0;
    int   ser_cnt = 0;
    logic force_busy = 1'b0;

    always #5 clk_i = ~clk_i;

    serializer_arb #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .MOD_W   (MOD_W),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .en_i        (en_i),
        .req_data_i  (req_data_i),
        .req_mod_i   (req_mod_i),
        .req_val_i   (req_val_i),
        .req_ready_o (req_ready_o),
        .ser_data_o  (ser_data_o),
        .ser_mod_o   (ser_mod_o),
        .ser_val_o   (ser_val_o),
        .ser_busy_i  (ser_busy_i),
        .grant_id_o  (grant_id_o),
        .grant_val_o (grant_val_o),
        .drop_o      (drop_o),
        .busy_o      (busy_o)
    );

    // Serializer stand-in.
    always @(posedge clk_i) begin
        if (!srst_i)
            ser_cnt <= 0;
        else if (ser_val_o && ser_mod_o != 4'd1 && ser_mod_o != 4'd2)
            ser_cnt <= (ser_mod_o == 4'(MOD_FULL)) ? int'(DATA_W) : int'(ser_mod_o);
        else if (ser_cnt > 0)
            ser_cnt <= ser_cnt - 1;
    end
    assign ser_busy_i = force_busy || (ser_cnt != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        tick();
        srst_i = 1'b0;
        tick();
        srst_i = 1'b1;
    endtask

    task automatic set_req(input int k, input logic [DATA_W-1:0] d, input logic [MOD_W-1:0] m);
        req_data_i[k*DATA_W +: DATA_W] = d;
        req_mod_i[k*MOD_W +: MOD_W]    = m;
    endtask

    function automatic int oh_idx(input logic [N_REQ-1:0] v);
        int r = -1;
        for (int k = 0; k < int'(N_REQ); k++)
            if (v[k]) r = (r == -1) ? k : -2;
        return r;
    endfunction

    // Record the next n grants (index and cycle) and check every launch word.
    task automatic collect(input int n, input logic [DATA_W-1:0] exp_data,
                           input logic [MOD_W-1:0] exp_mod,
                           output int ids[8], output int ts[8],
                           output logic [N_REQ-1:0] seen);
        int g = 0;
        seen = '0;
        for (int k = 0; k < 8; k++) begin
            ids[k] = -1;
            ts[k]  = -1;
        end
        for (int c = 0; c < 200 && g < n; c++) begin
            sample();
            seen |= req_ready_o;
            if (ser_val_o)
                check("launch_word", 32'({ser_mod_o, ser_data_o}), 32'({exp_mod, exp_data}));
            if (req_ready_o != '0) begin
                ids[g] = oh_idx(req_ready_o);
                ts[g]  = c;
                g++;
            end
        end
        check("collect_done", 32'(g), 32'(n));
    endtask

    initial begin
        int ids[8];
        int ts[8];
        logic [N_REQ-1:0] seen;
        int n;
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        int exp_en[4] = '{1, 3, 1, 3};

        srst_i     = 1'b1;
        en_i       = '0;
        req_val_i  = '0;
        req_data_i = '0;
        req_mod_i  = '0;

        // Reset then idle.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sample();
            check("idle", 32'({req_ready_o, ser_val_o, grant_val_o, drop_o, busy_o,
                               grant_id_o, ser_mod_o, ser_data_o}), 32'd0);
            tick();
        end

        // Single requester 2, full-length word.
        en_i = '1;
        set_req(2, 16'hDAAC, 4'(MOD_FULL));
        req_val_i = 4'b0100;
        sample();
        check("t2_ready", 32'({req_ready_o, ser_val_o}), 32'({4'b0100, 1'b0}));
        tick();
        req_val_i = '0;
        sample();
        check("t2_launch", 32'({ser_val_o, grant_val_o, busy_o, grant_id_o, ser_mod_o}),
              32'({1'b1, 1'b1, 1'b1, 2'd2, 4'd0}));
        check("t2_data", 32'(ser_data_o), 32'h0000DAAC);
        check("t2_ready_once", 32'(req_ready_o), 32'd0);
        n = 0;
        do begin
            sample();
            n++;
            if (n == 1) check("t2_val_pulse", 32'(ser_val_o), 32'd0);
            if (n == 9) check("t2_owner", 32'({grant_val_o, grant_id_o}), 32'({1'b1, 2'd2}));
        end while (busy_o && n < 40);
        check("t2_busy_len", 32'(n), 32'd18);
        check("t2_hold", 32'({grant_val_o, ser_val_o, grant_id_o, ser_data_o}),
              32'({1'b0, 1'b0, 2'd2, 16'hDAAC}));

        // Serializer busy while IDLE blocks any grant.
        tick();
        force_busy = 1'b1;
        req_val_i  = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("idle_busy_hold", 32'({req_ready_o, grant_val_o}), 32'd0);
            tick();
        end
        force_busy = 1'b0;
        req_val_i  = '0;

        // Round-robin fairness, all valid, length 5.
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 16'hFFFF, 4'd5);
        req_val_i = 4'b1111;
        collect(5, 16'hFFFF, 4'd5, ids, ts, seen);
        for (int k = 0; k < 5; k++) check("rr_order", 32'(ids[k]), 32'(exp_rr[k]));
        for (int k = 0; k < 4; k++) check("rr_gap", 32'(ts[k+1] - ts[k]), 32'd8);
        check("rr_seen", 32'(seen), 32'h0000000F);

        // Enable mask 1010.
        tick();
        en_i = 4'b1010;
        collect(4, 16'hFFFF, 4'd5, ids, ts, seen);
        for (int k = 0; k < 4; k++) check("en_order", 32'(ids[k]), 32'(exp_en[k]));
        for (int k = 0; k < 3; k++) check("en_gap", 32'(ts[k+1] - ts[k]), 32'd8);
        check("en_masked", 32'(seen & 4'b0101), 32'd0);
        req_val_i = '0;

        // Dropped launch: requester 0 with a rejected length.
        do_reset();
        en_i = '1;
        set_req(0, 16'h1234, 4'd1);
        set_req(1, 16'hABCD, 4'(MOD_FULL));
        req_val_i = 4'b0011;
        sample();
        check("t5_ready0", 32'(req_ready_o), 32'h00000001);
        tick();
        req_val_i = 4'b0010;
        sample();
        check("t5_launch", 32'({ser_val_o, ser_mod_o, grant_id_o}), 32'({1'b1, 4'd1, 2'd0}));
        tick();
        sample();
        check("t5_nodrop_a", 32'({drop_o, busy_o}), 32'b01);
        tick();
        sample();
        check("t5_nodrop_b", 32'({drop_o, busy_o}), 32'b01);
        tick();
        sample();
        check("t5_drop", 32'({drop_o, busy_o, grant_val_o, req_ready_o}),
              32'({1'b1, 1'b0, 1'b0, 4'b0010}));
        tick();
        set_req(0, 16'h0F0F, 4'(MOD_FULL));
        set_req(3, 16'h3333, 4'(MOD_FULL));
        req_val_i = 4'b1001;
        sample();
        check("t5_next", 32'({drop_o, ser_val_o, grant_id_o, ser_data_o}),
              32'({1'b0, 1'b1, 2'd1, 16'hABCD}));
        check("t5_no_ready", 32'(req_ready_o), 32'd0);

        // Reset during WAIT_DONE; pending 0 and 3, pointer must be back at 0.
        for (int k = 0; k < 5; k++) tick();
        sample();
        check("t6_in_xfer", 32'({grant_val_o, busy_o, ser_busy_i}), 32'b111);
        tick();
        srst_i = 1'b0;
        sample();
        check("t6_rst_noready", 32'(req_ready_o), 32'd0);
        tick();
        srst_i = 1'b1;
        sample();
        check("t6_after_rst", 32'({grant_val_o, busy_o, ser_val_o, drop_o, ser_data_o}), 32'd0);
        check("t6_ptr0", 32'(req_ready_o), 32'h00000001);
        tick();
        req_val_i = 4'b1000;
        sample();
        check("t6_launch0", 32'({ser_val_o, grant_id_o, ser_data_o}), 32'({1'b1, 2'd0, 16'h0F0F}));
        n = 0;
        do begin
            sample();
            n++;
        end while (req_ready_o == '0 && n < 40);
        check("t6_next3", 32'(req_ready_o), 32'h00000008);
        check("t6_next3_gap", 32'(n), 32'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
